// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM controller arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the arbiter: command/write data in, ack/err/read data out.
interface ram_arbiter_if;
  logic [17:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic        byte_op;
  logic        wr_inhibit;
  logic [15:0] data_out;
  logic        ack;
  logic        err;

  modport master (output addr, data_in, rd, wr, byte_op, wr_inhibit,
                  input  data_out, ack, err);
  modport slave  (input  addr, data_in, rd, wr, byte_op, wr_inhibit,
                  output data_out, ack, err);
endinterface

// File: rtl/ram_arb_port_mux.sv
// Combinational owner select of the command fields presented to the controller.
// rd and wr both high is treated as a write, so rd is masked by wr here.
module ram_arb_port_mux
  import ram_arbiter_pkg::*;
(
  input  port_t       sel,
  input  logic [17:0] a_addr,
  input  logic [15:0] a_data,
  input  logic        a_rd,
  input  logic        a_wr,
  input  logic        a_byte_op,
  input  logic        a_wr_inhibit,
  input  logic [17:0] b_addr,
  input  logic [15:0] b_data,
  input  logic        b_rd,
  input  logic        b_wr,
  input  logic        b_byte_op,
  input  logic        b_wr_inhibit,
  output logic [17:0] addr,
  output logic [15:0] data,
  output logic        rd,
  output logic        wr,
  output logic        byte_op,
  output logic        wr_inhibit
);

  // Pick the owner's live request fields
  always_comb begin
    addr       = a_addr;
    data       = a_data;
    rd         = a_rd & ~a_wr;
    wr         = a_wr;
    byte_op    = a_byte_op;
    wr_inhibit = a_wr_inhibit;
    if (sel == PORT_B) begin
      addr       = b_addr;
      data       = b_data;
      rd         = b_rd & ~b_wr;
      wr         = b_wr;
      byte_op    = b_byte_op;
      wr_inhibit = b_wr_inhibit;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the SRAM controller (CPU = port A, DMA = port B).
// Access sequence: IDLE grant -> BUSY until done/timeout -> one RECOVER cycle
// carrying the registered ack. Ties are round robin unless ARB_FIXED_PRIO_EN
// is defined, in which case port A always wins a tie.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave a,
  ram_arbiter_if.slave b,
  output logic [17:0]  mem_addr,
  output logic [15:0]  mem_data_in,
  input  logic [15:0]  mem_data_out,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic         mem_byte_op,
  output logic         mem_wr_inhibit,
  input  logic         mem_done,
  output logic         grant_b
);

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_t     state, state_nxt;
  port_t      owner, owner_nxt, last_grant;
  logic [3:0] cnt, cnt_inc;
  logic       start, done_ev, tmo_ev;
  logic       req_a, req_b, m_rd, m_wr;

  assign req_a   = a.rd | a.wr;
  assign req_b   = b.rd | b.wr;
  assign cnt_inc = cnt + 4'd1;

  ram_arb_port_mux u_mux (
    .sel          (owner),
    .a_addr       (a.addr),
    .a_data       (a.data_in),
    .a_rd         (a.rd),
    .a_wr         (a.wr),
    .a_byte_op    (a.byte_op),
    .a_wr_inhibit (a.wr_inhibit),
    .b_addr       (b.addr),
    .b_data       (b.data_in),
    .b_rd         (b.rd),
    .b_wr         (b.wr),
    .b_byte_op    (b.byte_op),
    .b_wr_inhibit (b.wr_inhibit),
    .addr         (mem_addr),
    .data         (mem_data_in),
    .rd           (m_rd),
    .wr           (m_wr),
    .byte_op      (mem_byte_op),
    .wr_inhibit   (mem_wr_inhibit)
  );

  // Command strobes only reach the controller while an access is in flight
  assign mem_rd  = (state == ST_BUSY) & m_rd;
  assign mem_wr  = (state == ST_BUSY) & m_wr;
  assign grant_b = (state != ST_IDLE) && (owner == PORT_B);

  // Next-state, grant decision and completion events
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    start     = 1'b0;
    done_ev   = 1'b0;
    tmo_ev    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_a || req_b) begin
          start     = 1'b1;
          state_nxt = ST_BUSY;
          if (req_a && req_b) begin
`ifdef ARB_FIXED_PRIO_EN
            owner_nxt = PORT_A;
`else
            if (last_grant == PORT_A) owner_nxt = PORT_B;
            else                      owner_nxt = PORT_A;
`endif
          end else if (req_a) begin
            owner_nxt = PORT_A;
          end else begin
            owner_nxt = PORT_B;
          end
        end
      end
      ST_BUSY: begin
        // done wins over a coincident timeout
        if (mem_done) begin
          done_ev   = 1'b1;
          state_nxt = ST_RECOVER;
        end else if (cnt_inc == TMO) begin
          tmo_ev    = 1'b1;
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, owner, timeout counter and per-port ack/err/read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= PORT_A;
      last_grant <= PORT_B;
      cnt        <= '0;
      a.ack      <= 1'b0;
      a.err      <= 1'b0;
      a.data_out <= '0;
      b.ack      <= 1'b0;
      b.err      <= 1'b0;
      b.data_out <= '0;
    end else begin
      state <= state_nxt;
      a.ack <= 1'b0;
      b.ack <= 1'b0;
      if (start) begin
        owner      <= owner_nxt;
        last_grant <= owner_nxt;
        cnt        <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt_inc;
      end
      if (done_ev || tmo_ev) begin
        if (owner == PORT_A) begin
          a.ack <= 1'b1;
          a.err <= tmo_ev;
          if (done_ev && m_rd) a.data_out <= mem_data_out;
        end else begin
          b.ack <= 1'b1;
          b.err <= tmo_ev;
          if (done_ev && m_rd) b.data_out <= mem_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: controller model answers one cycle after a command,
// a scoreboard of expected acks (port, err, read data) is checked on every ack.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        mem_rd, mem_wr, mem_byte_op, mem_wr_inhibit;
  logic        mem_done = 1'b0;
  logic        grant_b;

  ram_arbiter_if pa ();
  ram_arbiter_if pb ();

  ram_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .a              (pa),
    .b              (pb),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_byte_op    (mem_byte_op),
    .mem_wr_inhibit (mem_wr_inhibit),
    .mem_done       (mem_done),
    .grant_b        (grant_b)
  );

  always #5 clk = ~clk;

  // controller model: done one cycle after a command, single-cycle pulse
  logic        ctl_en = 1'b0;
  logic [15:0] ctl_rdata = '0;
  always @(posedge clk) begin
    mem_done     <= ctl_en && (mem_rd || mem_wr) && !mem_done;
    mem_data_out <= ctl_rdata;
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   acks_a = 0, acks_b = 0;
  int   cyc, a_left, b_left;
  logic s_ack_a, s_ack_b, s_rd, s_wr, s_gb;

  // scoreboard: every ack must match the oldest expected entry
  always @(negedge clk) begin
    if (pa.ack === 1'b1) acks_a++;
    if (pb.ack === 1'b1) acks_b++;
    if (pa.ack === 1'b1 || pb.ack === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected ack_a=%0b ack_b=%0b expected no ack", pa.ack, pb.ack);
      end else begin
        e = sbq.pop_front();
        if ((pa.ack && pb.ack) || (pb.ack !== e.port) ||
            ((e.port ? pb.err : pa.err) !== e.err) ||
            (e.rd && ((e.port ? pb.data_out : pa.data_out) !== e.data))) begin
          errors++;
          $display("FAIL sb_ack got ack_a=%0b ack_b=%0b err=%0b data=%h expected port=%0d err=%0b data=%h",
                   pa.ack, pb.ack, e.port ? pb.err : pa.err,
                   e.port ? pb.data_out : pa.data_out, e.port, e.err, e.data);
        end
      end
    end
  end

  // one cycle; snapshot outputs, then act as requester (drop after last ack)
  task automatic step;
    @(negedge clk);
    cyc++;
    s_ack_a = pa.ack; s_ack_b = pb.ack; s_rd = mem_rd; s_wr = mem_wr; s_gb = grant_b;
    if (pa.ack && a_left > 0) begin
      a_left--;
      if (a_left == 0) begin pa.rd = 1'b0; pa.wr = 1'b0; end
    end
    if (pb.ack && b_left > 0) begin
      b_left--;
      if (b_left == 0) begin pb.rd = 1'b0; pb.wr = 1'b0; end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    pa.addr = '0; pa.data_in = '0; pa.rd = 0; pa.wr = 0; pa.byte_op = 0; pa.wr_inhibit = 0;
    pb.addr = '0; pb.data_in = '0; pb.rd = 0; pb.wr = 0; pb.byte_op = 0; pb.wr_inhibit = 0;
    a_left = 0; b_left = 0; ctl_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({mem_rd, mem_wr, pa.ack, pb.ack, pa.err, pb.err, grant_b, pa.data_out, pb.data_out} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state rd=%b wr=%b acks=%b%b errs=%b%b gb=%b dout=%h/%h expected all 0",
               mem_rd, mem_wr, pa.ack, pb.ack, pa.err, pb.err, grant_b, pa.data_out, pb.data_out);
    end
  endtask

  task automatic test_single_read;
    int first_rd, rd_cnt, ack_cyc, b0;
    b0 = acks_b; first_rd = -1; rd_cnt = 0; ack_cyc = -1; cyc = 0;
    ctl_rdata = 16'h1234; pa.addr = 18'h00104; pa.rd = 1'b1; a_left = 1;
    sbq.push_back({1'b0, 1'b0, 1'b1, 16'h1234});
    repeat (6) begin
      step();
      if (s_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        checks++;
        if (mem_addr !== 18'h00104) begin errors++; $display("FAIL rd_addr got %h expected 00104", mem_addr); end
      end
      if (s_ack_a && ack_cyc < 0) ack_cyc = cyc;
    end
    checks++; if (first_rd != 1) begin errors++; $display("FAIL rd_start got %0d expected 1", first_rd); end
    checks++; if (rd_cnt != 2)   begin errors++; $display("FAIL rd_len got %0d expected 2", rd_cnt); end
    checks++; if (ack_cyc != 3)  begin errors++; $display("FAIL rd_ack_cyc got %0d expected 3", ack_cyc); end
    checks++; if (pa.data_out !== 16'h1234) begin errors++; $display("FAIL rd_data got %h expected 1234", pa.data_out); end
    checks++; if (acks_b != b0)  begin errors++; $display("FAIL rd_no_b_ack got %0d expected %0d", acks_b, b0); end
  endtask

  task automatic test_timeout;
    int rd_cnt, ack_cyc;
    logic got;
    rd_cnt = 0; got = 0; ack_cyc = -1;
    ctl_en = 1'b0; pa.addr = 18'h00200; pa.rd = 1'b1; a_left = 1;
    sbq.push_back({1'b0, 1'b1, 1'b0, 16'h0000});
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (s_rd) rd_cnt++;
      if (s_ack_a) got = 1;
    end
    checks++; if (!got)         begin errors++; $display("FAIL tmo_ack got none expected ack"); end
    checks++; if (rd_cnt != 15) begin errors++; $display("FAIL tmo_busy got %0d expected 15", rd_cnt); end
    checks++; if (pa.err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b expected 1", pa.err); end
    checks++; if (pa.data_out !== 16'h1234) begin errors++; $display("FAIL tmo_data got %h expected 1234", pa.data_out); end
    step();
    // next access completes normally
    got = 0; cyc = 0;
    ctl_en = 1'b1; ctl_rdata = 16'hBEEF; pa.rd = 1'b1; a_left = 1;
    sbq.push_back({1'b0, 1'b0, 1'b1, 16'hBEEF});
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (s_ack_a) begin got = 1; ack_cyc = cyc; end
    end
    checks++; if (ack_cyc != 3) begin errors++; $display("FAIL tmo_next_lat got %0d expected 3", ack_cyc); end
    checks++; if (pa.err !== 1'b0 || pa.data_out !== 16'hBEEF) begin
      errors++; $display("FAIL tmo_next got err=%b data=%h expected err=0 data=beef", pa.err, pa.data_out);
    end
    step();
  endtask

  task automatic test_sim_write;
    int a_cyc, b_cyc;
    do_reset();
    a_cyc = -1; b_cyc = -1; cyc = 0;
    pa.addr = 18'h00010; pa.data_in = 16'hAAAA; pa.wr = 1'b1; a_left = 1;
    pb.addr = 18'h00020; pb.data_in = 16'h5555; pb.wr = 1'b1; b_left = 1;
    sbq.push_back({1'b0, 1'b0, 1'b0, 16'h0000});
    sbq.push_back({1'b1, 1'b0, 1'b0, 16'h0000});
    for (int i = 0; i < 20 && (a_left > 0 || b_left > 0); i++) begin
      step();
      if (s_wr) begin
        checks++;
        if ((cyc < 4 && (s_gb !== 1'b0 || mem_data_in !== 16'hAAAA)) ||
            (cyc >= 4 && (s_gb !== 1'b1 || mem_data_in !== 16'h5555))) begin
          errors++; $display("FAIL wr_owner cyc=%0d got gb=%b data=%h", cyc, s_gb, mem_data_in);
        end
      end
      if (s_ack_a) a_cyc = cyc;
      if (s_ack_b) b_cyc = cyc;
    end
    checks++; if (a_cyc != 3) begin errors++; $display("FAIL wr_a_ack got %0d expected 3", a_cyc); end
    checks++; if (b_cyc != 7) begin errors++; $display("FAIL wr_b_ack got %0d expected 7", b_cyc); end
    step();
  endtask

  task automatic test_continuous;
    logic [7:0] ord, exp_ord;
    int n;
    do_reset();
    ord = '0; n = 0;
`ifdef ARB_FIXED_PRIO_EN
    exp_ord = 8'b0000_1111;
`else
    exp_ord = 8'b0101_0101;
`endif
    pa.wr = 1'b1; pb.wr = 1'b1; a_left = 4; b_left = 4;
    for (int i = 0; i < 8; i++) sbq.push_back({exp_ord[7-i], 1'b0, 1'b0, 16'h0000});
    for (int i = 0; i < 60 && (a_left > 0 || b_left > 0); i++) begin
      step();
      if (s_ack_a || s_ack_b) begin ord = {ord[6:0], s_ack_b}; n++; end
    end
    checks++; if (n != 8)        begin errors++; $display("FAIL cont_count got %0d expected 8", n); end
    checks++; if (ord !== exp_ord) begin errors++; $display("FAIL cont_order got %b expected %b", ord, exp_ord); end
    step();
  endtask

  task automatic test_byte_op;
    logic seen; int a0;
    seen = 0; a0 = acks_a;
    pb.addr = 18'h00003; pb.data_in = 16'h00CC; pb.byte_op = 1'b1; pb.wr_inhibit = 1'b1; pb.wr = 1'b1; b_left = 1;
    sbq.push_back({1'b1, 1'b0, 1'b0, 16'h0000});
    for (int i = 0; i < 10 && b_left > 0; i++) begin
      step();
      if (s_wr && !seen) begin
        seen = 1; checks++;
        if (mem_byte_op !== 1'b1 || mem_wr_inhibit !== 1'b1 || mem_addr !== 18'h00003 || s_gb !== 1'b1) begin
          errors++; $display("FAIL byte_pass got bo=%b inh=%b addr=%h gb=%b expected 1 1 00003 1",
                             mem_byte_op, mem_wr_inhibit, mem_addr, s_gb);
        end
      end
    end
    checks++; if (b_left != 0 || pb.err !== 1'b0) begin
      errors++; $display("FAIL byte_ack got left=%0d err=%b expected 0 0", b_left, pb.err);
    end
    checks++; if (acks_a != a0) begin errors++; $display("FAIL byte_no_a_ack got %0d expected %0d", acks_a, a0); end
    pb.byte_op = 1'b0; pb.wr_inhibit = 1'b0;
    step();
  endtask

  task automatic test_reset_busy;
    logic first_b, got_first;
    got_first = 0; first_b = 1'bx;
    ctl_en = 1'b0; pa.rd = 1'b1; pa.addr = 18'h00040;
    repeat (3) step();
    checks++; if (s_rd !== 1'b1) begin errors++; $display("FAIL rb_busy got mem_rd=%b expected 1", s_rd); end
    reset = 1'b1;
    step();
    checks++;
    if ({mem_rd, mem_wr, pa.ack, pb.ack, grant_b} !== 5'd0) begin
      errors++; $display("FAIL rb_reset got rd=%b wr=%b acks=%b%b gb=%b expected 0", mem_rd, mem_wr, pa.ack, pb.ack, grant_b);
    end
    reset = 1'b0; ctl_en = 1'b1; ctl_rdata = 16'h0F0F;
    pb.rd = 1'b1; a_left = 1; b_left = 1;
    sbq.push_back({1'b0, 1'b0, 1'b1, 16'h0F0F});
    sbq.push_back({1'b1, 1'b0, 1'b1, 16'h0F0F});
    for (int i = 0; i < 20 && (a_left > 0 || b_left > 0); i++) begin
      step();
      if ((s_ack_a || s_ack_b) && !got_first) begin got_first = 1; first_b = s_ack_b; end
    end
    checks++; if (first_b !== 1'b0) begin errors++; $display("FAIL rb_tie got first_b=%b expected 0", first_b); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_timeout();
    test_sim_write();
    test_continuous();
    test_byte_op();
    test_reset_busy();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single synchronous SRAM controller port (18-bit byte address, 16-bit data, rd/wr/done) between two requesters: CPU (port A) and DMA/bus-master (port B).
- Sequences each access: grant, hold command until controller done, recover cycle, registered acknowledge with captured read data.
- Sits between the CPU/Unibus DMA logic and the SRAM controller on the s3board top level.

Parameters:
- TIMEOUT, 15, cycles in BUSY without mem_done before the access is aborted with error (4-bit counter, 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_addr  in  18  port A byte address
- a_data_in  in  16  port A write data
- a_rd  in  1  port A read request, level, held until a_ack
- a_wr  in  1  port A write request, level, held until a_ack
- a_byte_op  in  1  port A byte access
- a_wr_inhibit  in  1  port A write suppress (cycle runs, no RAM write)
- a_data_out  out  16  port A read data, valid from a_ack onward until next a_ack
- a_ack  out  1  port A one-cycle completion pulse
- a_err  out  1  port A timeout flag, valid with a_ack
- b_addr, b_data_in, b_rd, b_wr, b_byte_op, b_wr_inhibit, b_data_out, b_ack, b_err: same as port A, for port B
- mem_addr  out  18  to controller addr
- mem_data_in  out  16  to controller data_in
- mem_data_out  in  16  from controller data_out
- mem_rd  out  1  to controller rd
- mem_wr  out  1  to controller wr
- mem_byte_op  out  1  to controller byte_op
- mem_wr_inhibit  out  1  to controller wr_inhibit
- mem_done  in  1  from controller done
- grant_b  out  1  debug: 1 while port B owns the controller

Behaviour:
- Reset (synchronous): state IDLE; mem_rd=mem_wr=0; a_ack=b_ack=0; a_err=b_err=0; a_data_out=b_data_out=0; grant_b=0; last_grant=B (so A wins first tie); timeout counter=0.
- States: IDLE, BUSY, RECOVER.
- IDLE: request = rd|wr of a port. Neither requesting -> stay. One requesting -> grant it. Both -> grant port != last_grant (round robin). On grant: latch owner, last_grant<=owner, counter<=0, go BUSY.
- BUSY: mem_* driven combinationally from the owner's live inputs (mem_rd = owner rd, mem_wr = owner wr); mem_addr/data/byte_op/wr_inhibit muxed by owner. Counter increments each cycle.
  - mem_done=1 -> go RECOVER; if owner rd, capture mem_data_out into owner's data_out register on this edge; owner ack<=1, err<=0.
  - counter reaches TIMEOUT with no mem_done -> go RECOVER; owner ack<=1, err<=1; data_out unchanged.
  - mem_done and timeout same cycle -> done wins, err=0.
- RECOVER (exactly 1 cycle): mem_rd=mem_wr=0 so the controller returns to idle; ack pulse high this cycle; next IDLE. Non-owner ack stays 0.
- Outside BUSY: mem_rd=mem_wr=0; mem_addr/data/byte_op/wr_inhibit follow last owner (no glitch requirement).
- Requester rule: drop rd/wr on the edge after ack, or keep high to request a new cycle; a request visible in IDLE is always a new access.
- Nominal latency: request in IDLE cycle 0 -> mem_rd at cycle 1 -> mem_done cycle 2 -> ack cycle 3 -> IDLE cycle 4; back-to-back throughput 1 access / 4 cycles with the standard controller.
- Both ports continuously requesting -> strict alternation A,B,A,B.
- Owner deasserting rd/wr mid-BUSY (protocol violation): mem command follows it; timeout eventually completes the access with err=1.
- rd and wr both high on a port: treated as write (mem_rd forced 0).

Optional Feature:
- ARB_FIXED_PRIO_EN: defined -> on simultaneous requests in IDLE port A (CPU) always wins; last_grant still tracked but ignored. Undefined -> round robin as above.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_BUSY, ST_RECOVER), port-select constants (PORT_A, PORT_B), default TIMEOUT.
- One natural sub-module: ram_arb_port_mux (combinational owner-select of addr/data/byte_op/wr_inhibit/rd/wr); FSM, counter, ack/data registers stay in ram_arbiter.

Test Plan:
- Single A read addr=18'h00104, controller model returns 16'h1234 on done -> mem_rd high cycles 1-2, a_ack pulse cycle 3, a_data_out=16'h1234, b_ack never.
- A and B write simultaneously (A data 16'hAAAA, B 16'h5555) -> A served first after reset, then B; grant_b low then high; two acks 4 cycles apart.
- Both ports request continuously 8 accesses -> grants alternate A,B,... ; with ARB_FIXED_PRIO_EN defined -> B never granted while A requests.
- Controller model never asserts done -> ack with err=1 after TIMEOUT=15 BUSY cycles; data_out unchanged; next request proceeds normally.
- Reset asserted during BUSY -> next cycle mem_rd=mem_wr=0, acks 0, state IDLE; subsequent tie grants A.
- B byte write with b_wr_inhibit=1, b_byte_op=1 -> mem_wr_inhibit and mem_byte_op pass through; b_ack after done, b_err=0.
